// File: rtl/sprite_line_sequencer_pkg.sv
// ============================================================================
// Module      : sprite_line_sequencer_pkg
// Description : Shared state encoding, descriptor layout and sprite geometry
//               for the sprite line sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_line_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_RUN      = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_t;

    localparam int DESC_VISIBLE_BIT = 31;
    localparam int DESC_INDEX_MSB   = 30;
    localparam int DESC_INDEX_LSB   = 22;
    localparam int DESC_X_MSB       = 21;
    localparam int DESC_X_LSB       = 12;
    localparam int DESC_Y_MSB       = 11;
    localparam int DESC_Y_LSB       = 3;
    localparam int DESC_HFLIP_BIT   = 2;

    localparam int SPRITE_DIM   = 20;
    localparam int SPRITE_WORDS = 400;
    localparam int SCREEN_X     = 480;

endpackage

`default_nettype wire

// File: rtl/sprite_line_sequencer_desc_decode.sv
// ============================================================================
// Module      : sprite_desc_decode
// Description : Combinational descriptor field extraction plus sprite row
//               computation and row range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_desc_decode
    import sprite_line_sequencer_pkg::*;
#(
    parameter int SIZE_X = 10,
    parameter int SIZE_Y = 9
) (
    input  logic [31:0]       i_desc,
    input  logic [SIZE_Y-1:0] i_pixel_y,
    output logic              o_visible,
    output logic [8:0]        o_sprite_index,
    output logic [SIZE_X-1:0] o_sprite_x,
    output logic              o_hflip,
    output logic [SIZE_Y:0]   o_row,
    output logic              o_row_in_range
);

    logic [SIZE_Y-1:0] w_sprite_y;
    logic              w_unused_reserved;

    assign o_visible      = i_desc[DESC_VISIBLE_BIT];
    assign o_sprite_index = i_desc[DESC_INDEX_MSB:DESC_INDEX_LSB];
    assign o_sprite_x     = SIZE_X'(i_desc[DESC_X_MSB:DESC_X_LSB]);
    assign w_sprite_y     = SIZE_Y'(i_desc[DESC_Y_MSB:DESC_Y_LSB]);
    assign o_hflip        = i_desc[DESC_HFLIP_BIT];
    assign w_unused_reserved = ^i_desc[1:0];

    // One extra bit so a scan line above the sprite shows up as negative.
    assign o_row          = {1'b0, i_pixel_y} - {1'b0, w_sprite_y};
    assign o_row_in_range = !o_row[SIZE_Y] && (o_row < (SIZE_Y+1)'(SPRITE_DIM));

endmodule

`default_nettype wire

// File: rtl/sprite_line_sequencer.sv
// ============================================================================
// Module      : sprite_line_sequencer
// Description : Emits the frame-memory addresses of one sprite line, one per
//               accepted beat. Optional horizontal flip: SPRITE_SEQ_HFLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_line_sequencer
    import sprite_line_sequencer_pkg::*;
#(
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 9,
    parameter int SIZE_ADDRESS = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sprite_on,
    input  logic [31:0]             sprite_datas,
    input  logic [SIZE_Y-1:0]       pixel_y,
    input  logic                    mem_ready,
    output logic [SIZE_ADDRESS-1:0] memory_address,
    output logic                    addr_valid,
    output logic [4:0]              col_index,
    output logic                    count_finished,
    output logic                    busy,
    output logic                    row_error
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [31:0]             r_desc;
    logic [SIZE_Y-1:0]       r_pixel_y;
    logic [SIZE_ADDRESS-1:0] r_base;
    logic [4:0]              r_col;
    logic                    r_row_error;

    logic                    w_visible;
    logic [8:0]              w_sprite_index;
    logic [SIZE_X-1:0]       w_sprite_x;
    logic                    w_hflip;
    logic [SIZE_Y:0]         w_row;
    logic                    w_row_in_range;
    logic [SIZE_ADDRESS-1:0] w_base;
    logic [SIZE_X:0]         w_x_next;
    logic                    w_last;
    logic [4:0]              w_col_offset;

    sprite_desc_decode #(
        .SIZE_X (SIZE_X),
        .SIZE_Y (SIZE_Y)
    ) u_decode (
        .i_desc         (r_desc),
        .i_pixel_y      (r_pixel_y),
        .o_visible      (w_visible),
        .o_sprite_index (w_sprite_index),
        .o_sprite_x     (w_sprite_x),
        .o_hflip        (w_hflip),
        .o_row          (w_row),
        .o_row_in_range (w_row_in_range)
    );

    assign w_base = (SIZE_ADDRESS'(w_sprite_index) * SIZE_ADDRESS'(SPRITE_WORDS))
                  + (SIZE_ADDRESS'(w_row) * SIZE_ADDRESS'(SPRITE_DIM));

    // Last beat of the line: final column, or the next column would be off-screen.
    assign w_x_next = (SIZE_X+1)'(w_sprite_x) + (SIZE_X+1)'(r_col) + (SIZE_X+1)'(1);
    assign w_last   = (r_col == 5'(SPRITE_DIM - 1)) || (w_x_next >= (SIZE_X+1)'(SCREEN_X));

`ifdef SPRITE_SEQ_HFLIP_EN
    assign w_col_offset = w_hflip ? (5'(SPRITE_DIM - 1) - r_col) : r_col;
`else
    logic w_unused_hflip;
    assign w_unused_hflip = w_hflip;
    assign w_col_offset   = r_col;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_desc      <= '0;
            r_pixel_y   <= '0;
            r_base      <= '0;
            r_col       <= '0;
            r_row_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (sprite_on) begin
                        r_desc    <= sprite_datas;
                        r_pixel_y <= pixel_y;
                    end
                end
                ST_SETUP: begin
                    r_base <= w_base;
                    r_col  <= '0;
                    if (w_visible && !w_row_in_range) begin
                        r_row_error <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A falling sprite_on aborts the line, so that beat is not counted.
                    if (sprite_on && mem_ready && !w_last) begin
                        r_col <= r_col + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next   = r_state;
        addr_valid     = 1'b0;
        count_finished = 1'b0;
        busy           = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (sprite_on) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!w_visible || !w_row_in_range) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                addr_valid = 1'b1;
                if (!sprite_on) begin
                    w_state_next = ST_IDLE;
                end else if (mem_ready && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                count_finished = 1'b1;
                w_state_next   = sprite_on ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!sprite_on) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign memory_address = addr_valid ? (r_base + SIZE_ADDRESS'(w_col_offset)) : '0;
    assign col_index      = r_col;
    assign row_error      = r_row_error;

endmodule

`default_nettype wire

// File: tb/tb_sprite_line_sequencer.sv
// ============================================================================
// Module      : tb_sprite_line_sequencer
// Description : Scoreboard bench for sprite_line_sequencer; expected beats are
//               queued when a request is driven and popped on accepted beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_line_sequencer;

`ifdef SPRITE_SEQ_HFLIP_EN
    localparam bit HF_EN = 1'b1;
`else
    localparam bit HF_EN = 1'b0;
`endif

    typedef struct {
        int addr;
        int col;
    } beat_t;

    logic        clk;
    logic        reset;
    logic        sprite_on;
    logic [31:0] sprite_datas;
    logic [8:0]  pixel_y;
    logic        mem_ready;
    logic [16:0] memory_address;
    logic        addr_valid;
    logic [4:0]  col_index;
    logic        count_finished;
    logic        busy;
    logic        row_error;

    beat_t exp_q[$];
    int    n_tests  = 0;
    int    n_failed = 0;
    int    cyc      = 0;
    int    n_accept, n_valid, n_finish;
    int    first_valid_cyc, last_accept_cyc, finish_cyc, start_cyc;

    sprite_line_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sprite_on      (sprite_on),
        .sprite_datas   (sprite_datas),
        .pixel_y        (pixel_y),
        .mem_ready      (mem_ready),
        .memory_address (memory_address),
        .addr_valid     (addr_valid),
        .col_index      (col_index),
        .count_finished (count_finished),
        .busy           (busy),
        .row_error      (row_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] make_desc(input logic vis, input int idx, input int x,
                                              input int y, input logic hf);
        logic [31:0] d;
        logic [31:0] vi;
        logic [31:0] vx;
        logic [31:0] vy;
        vi = idx;
        vx = x;
        vy = y;
        d = '0;
        d[31]    = vis;
        d[30:22] = vi[8:0];
        d[21:12] = vx[9:0];
        d[11:3]  = vy[8:0];
        d[2]     = hf;
        return d;
    endfunction

    // Reference model of one line: queue every beat the DUT should issue.
    task automatic push_line(input logic [31:0] desc, input logic [8:0] py, input int max_beats);
        int idx, x, y, row, base;
        bit hf;
        idx = int'(desc[30:22]);
        x   = int'(desc[21:12]);
        y   = int'(desc[11:3]);
        hf  = desc[2];
        row = int'(py) - y;
        if (!desc[31] || row < 0 || row >= 20) return;
        base = idx * 400 + row * 20;
        for (int c = 0; c < 20 && c < max_beats; c++) begin
            beat_t b;
            b.addr = (HF_EN && hf) ? base + 19 - c : base + c;
            b.col  = c;
            exp_q.push_back(b);
            if (x + c + 1 >= 480) break;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (count_finished) begin
            n_finish++;
            finish_cyc = cyc;
        end
        if (addr_valid) begin
            n_valid++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (addr_valid && mem_ready && sprite_on) begin
            n_accept++;
            last_accept_cyc = cyc;
            if (exp_q.size() > 0) begin
                beat_t b;
                b = exp_q.pop_front();
                check_value("beat_addr", 32'(memory_address), b.addr);
                check_value("beat_col", 32'(col_index), b.col);
            end else begin
                check_value("beat_without_expectation", exp_q.size(), 1);
            end
        end else if (addr_valid && !mem_ready && sprite_on && exp_q.size() > 0) begin
            check_value("stall_hold_addr", 32'(memory_address), exp_q[0].addr);
        end
    end

    // mode: 0 plain, 1 backpressure, 2 abort after 8 beats, 3 reset mid-line
    task automatic run_line(input string name, input logic [31:0] desc, input logic [8:0] py,
                            input int mode, input int max_beats, input int exp_valid,
                            input logic exp_rerr);
        int exp_n;
        n_accept = 0; n_valid = 0; n_finish = 0;
        first_valid_cyc = -1; last_accept_cyc = -1; finish_cyc = -1;
        @(posedge clk); #1;
        push_line(desc, py, max_beats);
        exp_n        = exp_q.size();
        sprite_datas = desc;
        pixel_y      = py;
        sprite_on    = 1'b1;
        mem_ready    = 1'b1;
        start_cyc    = cyc + 1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            mem_ready = !(mode == 1 && (k == 7 || k == 8 || k == 10));
            if (mode == 2 && k == 10) sprite_on = 1'b0;
            if (mode == 2 && k == 11) begin
                check_value({name, "_abort_addr_valid"}, addr_valid, 0);
                check_value({name, "_abort_busy"}, busy, 0);
            end
            if (mode == 3 && k == 6) begin
                reset = 1'b0;
                #1;
                check_value({name, "_rst_addr"}, 32'(memory_address), 0);
                check_value({name, "_rst_valid"}, addr_valid, 0);
                check_value({name, "_rst_col"}, 32'(col_index), 0);
                check_value({name, "_rst_finished"}, count_finished, 0);
                check_value({name, "_rst_busy"}, busy, 0);
                check_value({name, "_rst_row_error"}, row_error, 0);
                @(posedge clk); #1;
                sprite_on = 1'b0;
                reset     = 1'b1;
                exp_q.delete();
                break;
            end
            if (n_finish > 0) sprite_on = 1'b0;
        end
        sprite_on = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check_value({name, "_busy_end"}, busy, 0);
        check_value({name, "_finish_pulses"}, n_finish, (mode >= 2) ? 0 : 1);
        check_value({name, "_row_error"}, row_error, exp_rerr);
        if (mode != 3) begin
            check_value({name, "_accepted"}, n_accept, exp_n);
            check_value({name, "_valid_cycles"}, n_valid, exp_valid);
            check_value({name, "_sb_left"}, exp_q.size(), 0);
        end
        if (mode <= 1 && exp_n > 0) begin
            check_value({name, "_first_latency"}, first_valid_cyc - start_cyc, 2);
            check_value({name, "_finish_latency"}, finish_cyc - last_accept_cyc, 1);
        end
        exp_q.delete();
    endtask

    initial begin
        reset        = 1'b0;
        sprite_on    = 1'b0;
        sprite_datas = '0;
        pixel_y      = '0;
        mem_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_addr", 32'(memory_address), 0);
        check_value("reset_valid", addr_valid, 0);
        check_value("reset_col", 32'(col_index), 0);
        check_value("reset_finished", count_finished, 0);
        check_value("reset_busy", busy, 0);
        check_value("reset_row_error", row_error, 0);
        reset = 1'b1;

        run_line("nominal",   make_desc(1, 3, 100, 50, 0), 9'd57, 0, 20, 20, 0);
        run_line("stall",     make_desc(1, 3, 100, 50, 0), 9'd57, 1, 20, 23, 0);
        run_line("clip",      make_desc(1, 0, 470, 0, 0),  9'd0,  0, 20, 10, 0);
        run_line("invisible", make_desc(0, 3, 100, 50, 0), 9'd75, 0, 20, 0,  0);
        run_line("row_high",  make_desc(1, 3, 100, 50, 0), 9'd75, 0, 20, 0,  1);
        run_line("abort",     make_desc(1, 3, 100, 50, 0), 9'd57, 2, 8,  9,  1);
        run_line("reset_run", make_desc(1, 3, 100, 50, 0), 9'd57, 3, 20, 0,  0);
        run_line("hflip",     make_desc(1, 3, 100, 50, 1), 9'd57, 0, 20, 20, 0);
        run_line("row_neg",   make_desc(1, 5, 200, 50, 0), 9'd40, 0, 20, 0,  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_line_sequencer.md
Name: sprite_line_sequencer

Overview:
Sequences one sprite line for the print datapath. When the print controller raises sprite_on, this block decodes the sprite descriptor and emits the frame-memory addresses for the current line's 20 pixels, one per accepted beat. It then pulses count_finished so the print controller can return to coordinate lookup. It sits between the print controller, the sprite memory and the pixel output path, in the same clock domain.

Parameters:
SIZE_X, 10, pixel x coordinate width
SIZE_Y, 9, pixel y coordinate width
SIZE_ADDRESS, 17, memory address width
SPRITE_DIM, 20, sprite width and height in pixels
SCREEN_X, 480, visible width; columns at or beyond it are clipped

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
sprite_on  in  1  level request from print controller; high for the whole sprite line
sprite_datas  in  32  descriptor; [31] visible, [30:22] sprite_index, [21:12] sprite_x, [11:3] sprite_y, [2] hflip, [1:0] reserved
pixel_y  in  SIZE_Y  current scan line, sampled at request acceptance
mem_ready  in  1  memory accepts memory_address this cycle
memory_address  out  SIZE_ADDRESS  pixel address for the current beat
addr_valid  out  1  memory_address is valid
col_index  out  5  column (0..19) of the current beat, before flip
count_finished  out  1  one-cycle pulse: line complete
busy  out  1  high in every state except IDLE
row_error  out  1  sticky: a request arrived whose row is outside 0..SPRITE_DIM-1; cleared by reset only

Behaviour:
- Reset (async, active-low): state IDLE; memory_address=0, addr_valid=0, col_index=0, count_finished=0, busy=0, row_error=0. Reset mid-line abandons the line with no count_finished.
- IDLE: when sprite_on=1, latch sprite_datas and pixel_y, then go to SETUP.
- SETUP, 1 cycle:
  - row = pixel_y - sprite_y, computed 10-bit signed.
  - base = sprite_index*400 + row*20, registered; SPRITE_DIM products are fixed constants.
  - visible=0 -> DONE with no addresses.
  - row<0 or row>=SPRITE_DIM -> set row_error, go to DONE.
  - otherwise -> RUN with col=0.
- RUN:
  - addr_valid=1; memory_address = base + col.
  - Advance col only when addr_valid && mem_ready; hold address and col otherwise.
  - After the beat with col=SPRITE_DIM-1 accepted, or when sprite_x+col+1 >= SCREEN_X (clip), go to DONE.
  - sprite_on dropping in RUN aborts to IDLE: addr_valid=0 next cycle, no count_finished.
- DONE, 1 cycle: count_finished=1, addr_valid=0. Next state:
  - IDLE if sprite_on=0;
  - otherwise WAIT_LOW, which holds until sprite_on=0 so one request produces exactly one line.
- Latency: sprite_on high in IDLE -> first addr_valid 2 cycles later. Unstalled line = 20 cycles of addr_valid, then count_finished on the next cycle.
- Arithmetic: all address math is SIZE_ADDRESS bits, unsigned, truncating. Descriptors with sprite_index*400+399 >= 2^SIZE_ADDRESS are out of contract.
- sprite_x+col compared at SIZE_X+1 bits, so no wrap-around.
- Simultaneous mem_ready and sprite_on fall in RUN: abort wins, the beat is not counted.

Optional Feature:
Macro SPRITE_SEQ_HFLIP_EN.
- Defined: descriptor bit [2]=1 makes memory_address = base + (SPRITE_DIM-1-col). col_index and clipping still use the unflipped col.
- Not defined: bit [2] is ignored; addresses are always base + col.

Decomposition:
- Shared package: state encoding (IDLE, SETUP, RUN, DONE, WAIT_LOW); descriptor field bit positions; SPRITE_DIM; SPRITE_WORDS=400; SCREEN_X.
- Natural sub-module: sprite_desc_decode, combinational. It extracts fields and computes row and the in-range flag; the sequencer FSM and column counter stay in the top module.

Test Plan:
1. Nominal line, mem_ready=1: index=3, x=100, y=50, pixel_y=57 -> addresses 1340..1359 on 20 consecutive cycles, count_finished one cycle after address 1359, busy low after WAIT_LOW once sprite_on falls.
2. Backpressure: same descriptor, mem_ready low on beats 5 and 6 for 3 cycles -> address 1345 held 3 cycles, no skipped or duplicated address, 20 accepted beats total.
3. Clip: x=470, y=0, index=0, pixel_y=0 -> addresses 0..9 only, then count_finished.
4. Invalid cases:
   - y=50, pixel_y=75 -> row_error=1, zero addr_valid cycles, count_finished pulses.
   - visible=0 -> count_finished pulses, row_error unchanged.
5. Abort and reset: sprite_on falls after beat 7 -> addr_valid=0 next cycle, no count_finished, IDLE. Reset asserted in RUN -> all outputs reset values immediately.
6. With SPRITE_SEQ_HFLIP_EN and hflip=1, case 1 descriptor -> addresses 1359 down to 1340, col_index 0..19.
